data_wishbone_if: RTL and testbench
===================================

Name: data_wishbone_if

Overview:
- Wishbone B4 classic master that turns the MEM-stage data access (chip-enable, address, write data, byte select) into bus cycles.
- Raises a stall request that the ctrl block folds into the stall vector seen by all pipeline registers; it is the producer end of the stall/flush handshake that the pipeline registers consume.
- Holds read data until the pipeline releases, so a load completes exactly once even when other stages keep stalling.

Parameters:
- TIMEOUT_CYCLES, 256: BUSY-state cycles without ack before the transfer is aborted (used only with the optional feature).
- CNT_W, 9: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- stall_i  in  6  pipeline stall vector from ctrl
- flush_i  in  1  exception flush from ctrl
- cpu_ce_i  in  1  MEM stage requests a data access
- cpu_addr_i  in  32  byte address
- cpu_data_i  in  32  store data
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_sel_i  in  4  byte lane select
- cpu_data_o  out  32  load data to MEM stage
- stallreq_o  out  1  stall request to ctrl
- bus_err_o  out  1  transfer aborted by timeout
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_dat_i  in  32  Wishbone read data
- wb_we_o  out  1  Wishbone write enable
- wb_sel_o  out  4  Wishbone byte select
- wb_stb_o  out  1  Wishbone strobe
- wb_cyc_o  out  1  Wishbone cycle
- wb_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - wb_adr_o, wb_dat_o, internal read buffer rd_buf = 0x00000000.
  - wb_sel_o = 4'b0000; wb_we_o, wb_stb_o, wb_cyc_o = 0; timeout counter = 0.
  - Combinational outputs settle to: cpu_data_o = 0, stallreq_o = 0, bus_err_o = 0.
  - Reset mid-transfer drops cyc/stb immediately; the slave sees an aborted cycle.
- FSM states: IDLE, BUSY, WAIT_FOR_STALL. All wb_* outputs are registered.
- IDLE:
  - If cpu_ce_i=1 and flush_i=0:
    - Register wb_adr_o=cpu_addr_i, wb_dat_o=cpu_data_i, wb_we_o=cpu_we_i, wb_sel_o=cpu_sel_i, wb_stb_o=wb_cyc_o=1.
    - Clear the counter; next state BUSY.
  - Otherwise remain in IDLE.
- BUSY:
  - On flush_i=1: clear all wb_* outputs to reset values; next state IDLE. flush_i has priority over wb_ack_i.
  - Else, on wb_ack_i=1:
    - Clear all wb_* outputs to reset values.
    - If wb_we_o=0, capture rd_buf <= wb_dat_i.
    - Next state is WAIT_FOR_STALL if stall_i != 6'b000000, else IDLE.
  - Else: remain in BUSY; counter increments.
- WAIT_FOR_STALL:
  - Stays until stall_i == 0, then goes to IDLE.
  - flush_i=1 in this state forces IDLE and clears rd_buf.
- stallreq_o (combinational):
  - IDLE: 1 when cpu_ce_i=1 and flush_i=0.
  - BUSY: 1 unless wb_ack_i=1 or flush_i=1.
  - WAIT_FOR_STALL: 0.
- cpu_data_o (combinational):
  - BUSY with wb_ack_i=1 on a read: wb_dat_i.
  - WAIT_FOR_STALL: rd_buf.
  - Otherwise: 0.
- Latency: with a zero-wait slave (ack in the first BUSY cycle), stallreq_o is high for exactly 1 cycle and data is delivered in the 2nd cycle after cpu_ce_i is seen.
- Only one outstanding transfer at a time; no pipelined Wishbone.
- A new request in IDLE the cycle after returning from WAIT_FOR_STALL is legal and starts immediately.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- Defined:
  - In BUSY, when the counter reaches TIMEOUT_CYCLES-1 with no ack and no flush, the transfer is aborted: wb_* outputs are cleared, rd_buf <= 0, and next state follows the ack rules (WAIT_FOR_STALL or IDLE).
  - In that abort cycle bus_err_o=1 (single cycle), stallreq_o=0 and cpu_data_o=0.
- Undefined: the counter is not built, bus_err_o is tied to 0, and BUSY waits indefinitely.

Test Plan:
- Zero-wait load: cpu_ce_i=1, we=0, addr=0x00000010, slave acks in the first BUSY cycle with 0x12345678, stall_i=0 -> stallreq_o high 1 cycle; cpu_data_o=0x12345678 in the ack cycle; wb_cyc_o low the next cycle.
- Store with wait states: we=1, addr=0x00000020, data=0xCAFEBABE, sel=4'b0011, ack after 3 cycles -> wb_dat_o/wb_sel_o stable over 3 BUSY cycles; stallreq_o high 4 cycles total; return to IDLE.
- Held read: load acked with 0xA5A5A5A5 while stall_i=6'b001111 for 2 more cycles -> WAIT_FOR_STALL; cpu_data_o=0xA5A5A5A5 and stallreq_o=0 both cycles; IDLE once stall_i=0.
- Flush mid-transfer: flush_i=1 in the 2nd BUSY cycle while the slave also asserts ack -> cyc/stb drop, rd_buf not loaded, stallreq_o=0, state IDLE.
- Async reset: rst=0 asserted mid-BUSY between clock edges -> wb_cyc_o=0 immediately; all outputs at reset values before the next edge.
- Timeout (WB_TIMEOUT_EN, TIMEOUT_CYCLES=4): no ack -> bus_err_o=1 in the 4th BUSY cycle; cpu_data_o=0; next cycle IDLE with bus_err_o=0.

Source files
------------

// File: rtl/data_wishbone_if.sv
// Wishbone B4 classic master for MEM-stage data accesses, with a stall-request/hold-data handshake.
// Define WB_TIMEOUT_EN to build the BUSY-state timeout abort and bus_err_o.
module data_wishbone_if #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_W          = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall_i,
   input  logic        flush_i,
   input  logic        cpu_ce_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [31:0] cpu_data_i,
   input  logic        cpu_we_i,
   input  logic [3:0]  cpu_sel_i,
   output logic [31:0] cpu_data_o,
   output logic        stallreq_o,
   output logic        bus_err_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_stb_o,
   output logic        wb_cyc_o,
   input  logic        wb_ack_i
);

   typedef enum logic [1:0] {
      IDLE           = 2'b00,
      BUSY           = 2'b01,
      WAIT_FOR_STALL = 2'b10
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] wb_adr_q, wb_adr_d;
   logic [31:0] wb_dat_q, wb_dat_d;
   logic        wb_we_q, wb_we_d;
   logic [3:0]  wb_sel_q, wb_sel_d;
   logic        wb_cyc_q, wb_cyc_d;
   logic [31:0] rd_buf_q, rd_buf_d;
   logic        timeout_s;

`ifdef WB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign timeout_s = (state_q == BUSY) && !wb_ack_i && !flush_i &&
                      (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Timeout counter: counts consecutive BUSY cycles, zero everywhere else.
   always_comb begin
      if ((state_q == BUSY) && (state_d == BUSY)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = '0;
      end
   end

   // Timeout counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // Next-state and next bus-register values.
   always_comb begin
      state_d  = state_q;
      wb_adr_d = wb_adr_q;
      wb_dat_d = wb_dat_q;
      wb_we_d  = wb_we_q;
      wb_sel_d = wb_sel_q;
      wb_cyc_d = wb_cyc_q;
      rd_buf_d = rd_buf_q;
      case (state_q)
         IDLE: begin
            if (cpu_ce_i && !flush_i) begin
               wb_adr_d = cpu_addr_i;
               wb_dat_d = cpu_data_i;
               wb_we_d  = cpu_we_i;
               wb_sel_d = cpu_sel_i;
               wb_cyc_d = 1'b1;
               state_d  = BUSY;
            end else begin
               state_d  = IDLE;
            end
         end
         BUSY: begin
            if (flush_i || wb_ack_i || timeout_s) begin
               wb_adr_d = 32'h0000_0000;
               wb_dat_d = 32'h0000_0000;
               wb_we_d  = 1'b0;
               wb_sel_d = 4'b0000;
               wb_cyc_d = 1'b0;
               if (flush_i) begin
                  state_d = IDLE;
               end else begin
                  // Timeout ends like an ack but leaves an empty read buffer.
                  if (timeout_s) begin
                     rd_buf_d = 32'h0000_0000;
                  end else if (!wb_we_q) begin
                     rd_buf_d = wb_dat_i;
                  end else begin
                     rd_buf_d = rd_buf_q;
                  end
                  state_d = (stall_i != 6'b000000) ? WAIT_FOR_STALL : IDLE;
               end
            end else begin
               state_d = BUSY;
            end
         end
         WAIT_FOR_STALL: begin
            if (flush_i) begin
               rd_buf_d = 32'h0000_0000;
               state_d  = IDLE;
            end else if (stall_i == 6'b000000) begin
               state_d  = IDLE;
            end else begin
               state_d  = WAIT_FOR_STALL;
            end
         end
         default: begin
            wb_adr_d = 32'h0000_0000;
            wb_dat_d = 32'h0000_0000;
            wb_we_d  = 1'b0;
            wb_sel_d = 4'b0000;
            wb_cyc_d = 1'b0;
            state_d  = IDLE;
         end
      endcase
   end

   // FSM state and registered Wishbone outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         wb_adr_q <= 32'h0000_0000;
         wb_dat_q <= 32'h0000_0000;
         wb_we_q  <= 1'b0;
         wb_sel_q <= 4'b0000;
         wb_cyc_q <= 1'b0;
         rd_buf_q <= 32'h0000_0000;
      end else begin
         state_q  <= state_d;
         wb_adr_q <= wb_adr_d;
         wb_dat_q <= wb_dat_d;
         wb_we_q  <= wb_we_d;
         wb_sel_q <= wb_sel_d;
         wb_cyc_q <= wb_cyc_d;
         rd_buf_q <= rd_buf_d;
      end
   end

   // Pipeline-facing handshake: stall request and load data.
   always_comb begin
      stallreq_o = 1'b0;
      cpu_data_o = 32'h0000_0000;
      case (state_q)
         IDLE: begin
            stallreq_o = cpu_ce_i && !flush_i;
         end
         BUSY: begin
            stallreq_o = !(wb_ack_i || flush_i || timeout_s);
            if (wb_ack_i && !flush_i && !wb_we_q) begin
               cpu_data_o = wb_dat_i;
            end else begin
               cpu_data_o = 32'h0000_0000;
            end
         end
         WAIT_FOR_STALL: begin
            cpu_data_o = rd_buf_q;
         end
         default: begin
            stallreq_o = 1'b0;
         end
      endcase
   end

   assign bus_err_o = timeout_s;
   assign wb_adr_o  = wb_adr_q;
   assign wb_dat_o  = wb_dat_q;
   assign wb_we_o   = wb_we_q;
   assign wb_sel_o  = wb_sel_q;
   assign wb_stb_o  = wb_cyc_q;
   assign wb_cyc_o  = wb_cyc_q;

endmodule

// File: tb/tb_data_wishbone_if.sv
// Randomized self-checking bench for data_wishbone_if with a transaction-level slave/pipeline model.
module tb_data_wishbone_if;

   logic        clk;
   logic        rst;
   logic [5:0]  stall_i;
   logic        flush_i;
   logic        cpu_ce_i;
   logic [31:0] cpu_addr_i;
   logic [31:0] cpu_data_i;
   logic        cpu_we_i;
   logic [3:0]  cpu_sel_i;
   logic [31:0] cpu_data_o;
   logic        stallreq_o;
   logic        bus_err_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_we_o;
   logic [3:0]  wb_sel_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;
   logic        wb_ack_i;

`ifdef WB_TIMEOUT_EN
   localparam int MAX_W = 2;
`else
   localparam int MAX_W = 6;
`endif

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] mem [16];
   logic [31:0] rd_buf_m;

   data_wishbone_if #(.TIMEOUT_CYCLES(4), .CNT_W(9)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
      .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
      .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
      .stallreq_o(stallreq_o), .bus_err_o(bus_err_o), .wb_adr_o(wb_adr_o),
      .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
      .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
      .wb_ack_i(wb_ack_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) r[b*8 +: 8] = d[b*8 +: 8];
      end
      return r;
   endfunction

   task automatic check_bus_idle(input string tag);
      check_eq({tag, "_cyc"}, {31'd0, wb_cyc_o}, 32'd0);
      check_eq({tag, "_stb"}, {31'd0, wb_stb_o}, 32'd0);
      check_eq({tag, "_adr"}, wb_adr_o, 32'd0);
      check_eq({tag, "_dat"}, wb_dat_o, 32'd0);
      check_eq({tag, "_we"},  {31'd0, wb_we_o}, 32'd0);
      check_eq({tag, "_sel"}, {28'd0, wb_sel_o}, 32'd0);
   endtask

   // One complete access as seen by the pipeline; entered and left at posedge+1 in the idle state.
   task automatic access(input logic [31:0] addr, input logic [31:0] data, input logic we,
                         input logic [3:0] sel, input int waits, input int n_wait,
                         input int flush_busy, input logic flush_wait);
      logic [31:0] rval;
      logic        aborted;
      logic        stop;
      int          idx;
      idx = int'(addr[5:2]);
      rval = mem[idx];
      aborted = 1'b0;
      cpu_ce_i = 1'b1; cpu_addr_i = addr; cpu_data_i = data; cpu_we_i = we; cpu_sel_i = sel;
      flush_i = 1'b0; wb_ack_i = 1'b0; stall_i = 6'd0;
      #1;
      check_eq("req_stallreq", {31'd0, stallreq_o}, 32'd1);
      check_eq("req_cpu_data", cpu_data_o, 32'd0);
      @(posedge clk); #1;
      for (int i = 0; i <= waits; i++) begin
         if (!aborted) begin
            cpu_ce_i = 1'($urandom); cpu_addr_i = $urandom; cpu_data_i = $urandom;
            cpu_we_i = 1'($urandom); cpu_sel_i = 4'($urandom);
            wb_ack_i = (i == waits);
            flush_i  = (i == flush_busy);
            wb_dat_i = (wb_ack_i && !we) ? rval : $urandom;
            stall_i  = (wb_ack_i && n_wait == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            #1;
            check_eq("busy_cyc", {31'd0, wb_cyc_o}, 32'd1);
            check_eq("busy_stb", {31'd0, wb_stb_o}, 32'd1);
            check_eq("busy_adr", wb_adr_o, addr);
            check_eq("busy_dat", wb_dat_o, data);
            check_eq("busy_we",  {31'd0, wb_we_o}, {31'd0, we});
            check_eq("busy_sel", {28'd0, wb_sel_o}, {28'd0, sel});
            check_eq("busy_err", {31'd0, bus_err_o}, 32'd0);
            check_eq("busy_stallreq", {31'd0, stallreq_o}, {31'd0, !(wb_ack_i || flush_i)});
            check_eq("busy_cpu_data", cpu_data_o, (wb_ack_i && !flush_i && !we) ? rval : 32'd0);
            if (wb_ack_i && we) mem[idx] = merge(mem[idx], data, sel);
            if (wb_ack_i && !we && !flush_i) rd_buf_m = rval;
            aborted = flush_i;
            @(posedge clk); #1;
         end
      end
      wb_ack_i = 1'b0; flush_i = 1'b0; cpu_ce_i = 1'b0;
      check_bus_idle("post");
      stop = aborted;
      for (int j = 0; j < n_wait; j++) begin
         if (!stop) begin
            stall_i  = (j == n_wait - 1) ? 6'd0 : 6'($urandom_range(1, 63));
            flush_i  = flush_wait && (j == 0);
            cpu_ce_i = 1'($urandom);
            #1;
            check_eq("hold_stallreq", {31'd0, stallreq_o}, 32'd0);
            check_eq("hold_cpu_data", cpu_data_o, rd_buf_m);
            if (flush_i) begin
               rd_buf_m = 32'd0;
               stop = 1'b1;
            end
            @(posedge clk); #1;
         end
      end
      cpu_ce_i = 1'b0; flush_i = 1'b0; stall_i = 6'd0;
      #1;
      check_eq("back_idle_stallreq", {31'd0, stallreq_o}, 32'd0);
      check_eq("back_idle_cpu_data", cpu_data_o, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int          w;
      int          fb;
      logic [31:0] a;
      rst = 1'b0; stall_i = 6'd0; flush_i = 1'b0; cpu_ce_i = 1'b0; cpu_addr_i = 32'd0;
      cpu_data_i = 32'd0; cpu_we_i = 1'b0; cpu_sel_i = 4'd0; wb_dat_i = 32'd0; wb_ack_i = 1'b0;
      rd_buf_m = 32'd0;
      for (int k = 0; k < 16; k++) mem[k] = $urandom;
      #2;
      check_bus_idle("reset");
      check_eq("reset_stallreq", {31'd0, stallreq_o}, 32'd0);
      check_eq("reset_cpu_data", cpu_data_o, 32'd0);
      check_eq("reset_bus_err", {31'd0, bus_err_o}, 32'd0);
      #20 rst = 1'b1;
      @(posedge clk); #1;

      // Directed scenarios from the block's intended use
      mem[4] = 32'h1234_5678;
      access(32'h0000_0010, 32'h0, 1'b0, 4'hF, 0, 0, -1, 1'b0);
      access(32'h0000_0020, 32'hCAFE_BABE, 1'b1, 4'b0011, 3, 0, -1, 1'b0);
      mem[3] = 32'hA5A5_A5A5;
      access(32'h0000_000C, 32'h0, 1'b0, 4'hF, 1, 2, -1, 1'b0);
      access(32'h0000_0004, 32'h0, 1'b0, 4'hF, 1, 0, 1, 1'b0);
      access(32'h0000_0008, 32'h1111_2222, 1'b1, 4'hF, 0, 1, -1, 1'b0);

      // Request under flush in IDLE must not start a cycle
      cpu_ce_i = 1'b1; flush_i = 1'b1; cpu_addr_i = 32'h40;
      #1;
      check_eq("flush_idle_stallreq", {31'd0, stallreq_o}, 32'd0);
      @(posedge clk); #1;
      cpu_ce_i = 1'b0; flush_i = 1'b0;
      check_eq("flush_idle_cyc", {31'd0, wb_cyc_o}, 32'd0);
      @(posedge clk); #1;

      for (int n = 0; n < 40; n++) begin
         w  = $urandom_range(0, MAX_W);
         fb = ($urandom_range(0, 5) == 0) ? $urandom_range(0, w) : -1;
         a  = {26'd0, 4'($urandom), 2'b00};
         access(a, $urandom, 1'($urandom), 4'($urandom), w, $urandom_range(0, 3), fb,
                ($urandom_range(0, 4) == 0));
      end

      // Asynchronous reset in the middle of a BUSY cycle
      cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h30; cpu_sel_i = 4'hF;
      @(posedge clk); #1;
      cpu_ce_i = 1'b0;
      check_eq("pre_reset_cyc", {31'd0, wb_cyc_o}, 32'd1);
      #2 rst = 1'b0;
      #1;
      check_bus_idle("async_reset");
      check_eq("async_reset_stallreq", {31'd0, stallreq_o}, 32'd0);
      check_eq("async_reset_cpu_data", cpu_data_o, 32'd0);
      rd_buf_m = 32'd0;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      access(32'h0000_0018, 32'h5555_AAAA, 1'b1, 4'hF, 0, 1, -1, 1'b0);

`ifdef WB_TIMEOUT_EN
      mem[5] = 32'hDEAD_BEEF;
      access(32'h0000_0014, 32'h0, 1'b0, 4'hF, 0, 0, -1, 1'b0);
      cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h24; cpu_sel_i = 4'hF; stall_i = 6'd0;
      @(posedge clk); #1;
      cpu_ce_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_eq("to_cyc", {31'd0, wb_cyc_o}, 32'd1);
         check_eq("to_bus_err", {31'd0, bus_err_o}, {31'd0, (i == 3)});
         check_eq("to_stallreq", {31'd0, stallreq_o}, {31'd0, (i != 3)});
         check_eq("to_cpu_data", cpu_data_o, 32'd0);
         @(posedge clk); #1;
      end
      rd_buf_m = 32'd0;
      check_bus_idle("to_after");
      check_eq("to_after_err", {31'd0, bus_err_o}, 32'd0);
      check_eq("to_after_stallreq", {31'd0, stallreq_o}, 32'd0);
      access(32'h0000_0028, 32'h7777_8888, 1'b1, 4'hF, 0, 1, -1, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
